tree_cfg_sequencer: RTL and testbench

Sequencer that assigns router IDs and hierarchical addresses to every router of a K-ary, L-layer tree NoC at bring-up. It walks the tree root-first, level by level, and emits one `{router_id, router_addr}` record per router over a valid/ready configuration channel. The records feed the per-router `router_config_t` registers, replacing elaboration-time constant addressing with a runtime-loadable configuration path. It sits beside the tree NoC top, driven from the SoC reset/boot controller.

---
 rtl/tree_cfg_sequencer_pkg.sv | 46 ++++
 rtl/tree_cfg_sequencer_digit_counter.sv | 56 +++++
 rtl/tree_cfg_sequencer.sv | 136 +++++++++++++
 tb/tb_tree_cfg_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/tree_cfg_sequencer_pkg.sv
// Shared NoC helpers for the tree configuration sequencer.
//   powi / sum_powi : integer power and geometric sum used to size the tree
//   log2            : ceiling log2, minimum result 1
//   tree_cfg_rec_t  : one configuration record {router_id, router_addr}
//   tree_cfg_state_e: sequencer FSM states
package tree_cfg_sequencer_pkg;

    // Record fields are sized for the largest supported tree. Instances
    // narrow them to their own NRw / Lw+LKw widths.
    localparam int CFG_ID_MAX_W   = 16;
    localparam int CFG_ADDR_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } tree_cfg_state_e;

    typedef struct packed {
        logic [CFG_ID_MAX_W-1:0]   router_id;
        logic [CFG_ADDR_MAX_W-1:0] router_addr;
    } tree_cfg_rec_t;

    function automatic int powi(input int base, input int expo);
        int r;
        r = 1;
        for (int i = 0; i < expo; i++) r = r * base;
        return r;
    endfunction

    // sum over i=0..n-1 of base^i
    function automatic int sum_powi(input int base, input int n);
        int r;
        r = 0;
        for (int i = 0; i < n; i++) r = r + powi(base, i);
        return r;
    endfunction

    function automatic int log2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/tree_cfg_sequencer_digit_counter.sv
// Mixed-radix (base-K) digit vector with increment at a selectable digit.
//   clk, rst : clock, async active-high reset
//   clr      : zero all digits (wins over inc)
//   inc      : add one at digit idx, rippling carry towards digit L-1
//   idx      : digit index where the increment lands
//   digits   : digit i lives at [i*Kw +: Kw]
module tree_digit_counter
    import tree_cfg_sequencer_pkg::*;
#(
    parameter int K   = 2,
    parameter int L   = 3,
    parameter int Kw  = 1,
    parameter int Lw  = 2,
    parameter int LKw = L * Kw
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           inc,
    input  logic           clr,
    input  logic [Lw-1:0]  idx,
    output logic [LKw-1:0] digits
);

    logic [LKw-1:0] digits_q;
    logic [LKw-1:0] digits_d;
    logic           carry;

    always_comb begin
        digits_d = digits_q;
        carry    = 1'b0;
        if (clr) begin
            digits_d = '0;
        end else if (inc) begin
            carry = 1'b1;
            // Digits below idx are untouched; a carry out of digit L-1 is dropped.
            for (int i = 0; i < L; i++) begin
                if (i >= int'(idx) && carry) begin
                    if (digits_q[i*Kw +: Kw] == Kw'(K - 1)) begin
                        digits_d[i*Kw +: Kw] = '0;
                    end else begin
                        digits_d[i*Kw +: Kw] = digits_q[i*Kw +: Kw] + Kw'(1);
                        carry                = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) digits_q <= '0;
        else     digits_q <= digits_d;
    end

    assign digits = digits_q;

endmodule

// File: rtl/tree_cfg_sequencer.sv
// Bring-up sequencer: walks a K-ary, L-layer tree root-first, level by level,
// emitting one {router_id, {layer, pos}} record per router over valid/ready.
//   clk, reset        : clock, async active-high reset
//   start             : starts / restarts a sweep from IDLE or DONE
//   cfg_valid/ready   : record handshake
//   cfg_router_id     : router ID (NRw bits)
//   cfg_router_addr   : {layer, pos digits}
//   busy              : high while issuing records
//   done              : sticky after the final record is accepted
//
// state    | meaning
// ST_IDLE  | after reset, waiting for start (or auto-start)
// ST_ISSUE | presenting records, advancing on each handshake
// ST_DONE  | all records accepted, done held high
module tree_cfg_sequencer
    import tree_cfg_sequencer_pkg::*;
#(
    parameter int K          = 2,
    parameter int L          = 3,
    parameter int Kw         = 1,
    parameter int Lw         = 2,
    parameter int LKw        = L * Kw,
    parameter int NR         = sum_powi(K, L),
    parameter int NRw        = 3,
    parameter int AUTO_START = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                cfg_valid,
    input  logic                cfg_ready,
    output logic [NRw-1:0]      cfg_router_id,
    output logic [Lw+LKw-1:0]   cfg_router_addr,
    output logic                busy,
    output logic                done
);

    tree_cfg_state_e state_q;
    logic [NRw-1:0]  id_q;
    logic [NRw-1:0]  level_last_q;
    logic [Lw-1:0]   layer_q;
    logic [LKw-1:0]  pos_cnt_q;
    logic            valid_q;
    logic            busy_q;
    logic            done_q;
    logic [LKw-1:0]  digits;

    logic hs;
    logic last_rec;
    logic level_end;
    logic enter_issue;
    logic dig_inc;
    logic dig_clr;

    always_comb begin
        hs          = valid_q && cfg_ready;
        last_rec    = (id_q == NRw'(NR - 1));
        level_end   = (32'(pos_cnt_q) == 32'(level_last_q));
        enter_issue = ((state_q == ST_IDLE) && (start || (AUTO_START != 0))) ||
                      ((state_q == ST_DONE) && start);
        dig_clr     = enter_issue || (hs && !last_rec && level_end);
        dig_inc     = hs && !last_rec && !level_end;
    end

    tree_digit_counter #(
        .K   (K),
        .L   (L),
        .Kw  (Kw),
        .Lw  (Lw),
        .LKw (LKw)
    ) u_digits (
        .clk    (clk),
        .rst    (reset),
        .inc    (dig_inc),
        .clr    (dig_clr),
        .idx    (layer_q),
        .digits (digits)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            id_q         <= '0;
            level_last_q <= '0;
            layer_q      <= '0;
            pos_cnt_q    <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            if (enter_issue) begin
                state_q      <= ST_ISSUE;
                id_q         <= '0;
                level_last_q <= '0;
                layer_q      <= Lw'(L - 1);
                pos_cnt_q    <= '0;
                valid_q      <= 1'b1;
                busy_q       <= 1'b1;
                done_q       <= 1'b0;
            end else if (state_q == ST_ISSUE && hs) begin
                if (last_rec) begin
                    state_q <= ST_DONE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    id_q <= id_q + NRw'(1);
                    if (level_end) begin
                        layer_q      <= layer_q - Lw'(1);
                        pos_cnt_q    <= '0;
                        level_last_q <= NRw'((int'(level_last_q) + 1) * K - 1);
                    end else begin
                        pos_cnt_q <= pos_cnt_q + LKw'(1);
                    end
                end
            end
        end
    end

    // Record is packed through the shared record type; the fields are wider
    // than this instance needs, so the spare high bits are tied off below.
    tree_cfg_rec_t rec;
    logic          unused_rec_hi;

    assign rec.router_id   = CFG_ID_MAX_W'(id_q);
    assign rec.router_addr = CFG_ADDR_MAX_W'({layer_q, digits});
    assign unused_rec_hi   = ^{rec.router_id[CFG_ID_MAX_W-1:NRw],
                               rec.router_addr[CFG_ADDR_MAX_W-1:Lw+LKw]};

    assign cfg_valid       = valid_q;
    assign cfg_router_id   = rec.router_id[NRw-1:0];
    assign cfg_router_addr = rec.router_addr[Lw+LKw-1:0];
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_tree_cfg_sequencer.sv
module tb_tree_cfg_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // A: defaults, auto-start
    logic       rst_a, start_a, ready_a, valid_a, busy_a, done_a;
    logic [2:0] id_a;
    logic [4:0] addr_a;
    // B: K=4, L=3, auto-start
    logic       rst_b, start_b, ready_b, valid_b, busy_b, done_b;
    logic [4:0] id_b;
    logic [7:0] addr_b;
    // C: defaults, explicit start
    logic       rst_c, start_c, ready_c, valid_c, busy_c, done_c;
    logic [2:0] id_c;
    logic [4:0] addr_c;

    tree_cfg_sequencer #(.AUTO_START(1)) u_a (
        .clk(clk), .reset(rst_a), .start(start_a), .cfg_valid(valid_a), .cfg_ready(ready_a),
        .cfg_router_id(id_a), .cfg_router_addr(addr_a), .busy(busy_a), .done(done_a));

    tree_cfg_sequencer #(.K(4), .L(3), .Kw(2), .Lw(2), .NRw(5), .AUTO_START(1)) u_b (
        .clk(clk), .reset(rst_b), .start(start_b), .cfg_valid(valid_b), .cfg_ready(ready_b),
        .cfg_router_id(id_b), .cfg_router_addr(addr_b), .busy(busy_b), .done(done_b));

    tree_cfg_sequencer #(.AUTO_START(0)) u_c (
        .clk(clk), .reset(rst_c), .start(start_c), .cfg_valid(valid_c), .cfg_ready(ready_c),
        .cfg_router_id(id_c), .cfg_router_addr(addr_c), .busy(busy_c), .done(done_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    logic [4:0] exp_a [0:6];
    int         cnt;
    int         hs_b;
    logic       hold;
    logic [2:0] hid;
    logic [4:0] haddr;

    initial begin
        exp_a[0] = 5'h10; exp_a[1] = 5'h08; exp_a[2] = 5'h0A; exp_a[3] = 5'h00;
        exp_a[4] = 5'h01; exp_a[5] = 5'h02; exp_a[6] = 5'h03;

        rst_a = 1; rst_b = 1; rst_c = 1;
        start_a = 0; start_b = 0; start_c = 0;
        ready_a = 1; ready_b = 1; ready_c = 1;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_valid", 32'(valid_a), 0);
        chk("rst_busy",  32'(busy_a),  0);
        chk("rst_done",  32'(done_a),  0);
        chk("rst_id",    32'(id_a),    0);
        chk("rst_addr",  32'(addr_a),  0);

        // Scenario 1: full sweep, ready held high
        rst_a = 0;
        chk("s1_no_valid_before_edge", 32'(valid_a), 0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("s1_valid", 32'(valid_a), 1);
            chk("s1_busy",  32'(busy_a),  1);
            chk("s1_id",    32'(id_a),    32'(i));
            chk("s1_addr",  32'(addr_a),  32'(exp_a[i]));
        end
        @(negedge clk);
        chk("s1_done",       32'(done_a),  1);
        chk("s1_valid_low",  32'(valid_a), 0);
        chk("s1_busy_low",   32'(busy_a),  0);
        repeat (2) @(negedge clk);
        chk("s1_done_sticky", 32'(done_a), 1);

        // Scenario 2: random backpressure
        rst_a = 1;
        @(negedge clk);
        rst_a = 0;
        cnt  = 0;
        hold = 0;
        hid  = '0;
        haddr = '0;
        for (int cyc = 0; cyc < 200 && !done_a; cyc++) begin
            @(negedge clk);
            if (valid_a) begin
                if (cnt < 7) begin
                    chk("bp_id",   32'(id_a),   32'(cnt));
                    chk("bp_addr", 32'(addr_a), 32'(exp_a[cnt]));
                end else begin
                    chk("bp_extra_record", 32'(cnt), 6);
                end
                if (hold) chk("bp_stable", 32'({id_a, addr_a}), 32'({hid, haddr}));
            end
            ready_a = 1'($urandom_range(0, 1));
            hold  = valid_a && !ready_a;
            hid   = id_a;
            haddr = addr_a;
            if (valid_a && ready_a) cnt++;
        end
        chk("bp_handshakes", 32'(cnt), 7);
        chk("bp_done",       32'(done_a), 1);
        ready_a = 1;

        // Reset mid-sweep
        rst_a = 1;
        @(negedge clk);
        rst_a = 0;
        repeat (4) @(negedge clk);
        chk("mr_id_before", 32'(id_a), 3);
        rst_a = 1;
        #1;
        chk("mr_valid", 32'(valid_a), 0);
        chk("mr_busy",  32'(busy_a),  0);
        chk("mr_done",  32'(done_a),  0);
        chk("mr_id",    32'(id_a),    0);
        chk("mr_addr",  32'(addr_a),  0);
        @(negedge clk);
        rst_a = 0;
        @(negedge clk);
        chk("mr_restart_valid", 32'(valid_a), 1);
        chk("mr_restart_id",    32'(id_a),    0);
        chk("mr_restart_addr",  32'(addr_a),  32'h10);

        // Scenario K=4, L=3
        rst_b = 0;
        hs_b  = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (valid_b && id_b == 5'd0)  chk("k4_id0_addr",  32'(addr_b), 32'h80);
            if (valid_b && id_b == 5'd1)  chk("k4_id1_addr",  32'(addr_b), 32'h40);
            if (valid_b && id_b == 5'd4)  chk("k4_id4_addr",  32'(addr_b), 32'h4C);
            if (valid_b && id_b == 5'd5)  chk("k4_id5_addr",  32'(addr_b), 32'h00);
            if (valid_b && id_b == 5'd20) chk("k4_id20_addr", 32'(addr_b), 32'h0F);
            if (valid_b && ready_b) hs_b++;
        end
        chk("k4_handshakes", 32'(hs_b), 21);
        chk("k4_done",       32'(done_b), 1);

        // AUTO_START=0
        rst_c = 0;
        repeat (5) @(negedge clk);
        chk("as0_no_valid", 32'(valid_c), 0);
        chk("as0_no_busy",  32'(busy_c),  0);
        ready_c = 0;
        start_c = 1;
        @(negedge clk);
        start_c = 0;
        chk("as0_valid_after_start", 32'(valid_c), 1);
        chk("as0_first_id",          32'(id_c),    0);
        @(negedge clk);
        chk("as0_held_id", 32'(id_c), 0);
        start_c = 1;
        @(negedge clk);
        start_c = 0;
        @(negedge clk);
        chk("as0_start_ignored_id",    32'(id_c),    0);
        chk("as0_start_ignored_valid", 32'(valid_c), 1);
        ready_c = 1;
        repeat (2) @(negedge clk);
        chk("as0_advanced_id",   32'(id_c),   2);
        chk("as0_advanced_addr", 32'(addr_c), 32'h0A);
        cnt = 0;
        for (int cyc = 0; cyc < 20 && !done_c; cyc++) begin
            @(negedge clk);
            cnt++;
        end
        chk("as0_done",     32'(done_c), 1);
        chk("as0_tail_len", 32'(cnt),    5);
        start_c = 1;
        @(negedge clk);
        start_c = 0;
        chk("as0_restart_done_clr", 32'(done_c),  0);
        chk("as0_restart_valid",    32'(valid_c), 1);
        chk("as0_restart_id",       32'(id_c),    0);
        for (int i = 1; i < 7; i++) begin
            @(negedge clk);
            chk("as0_rerun_addr", 32'(addr_c), 32'(exp_a[i]));
        end
        @(negedge clk);
        chk("as0_redone", 32'(done_c), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
